// File: rtl/instruction_fetch_stage_if.sv
// instruction_fetch_stage_if: fetch-stage bus bundling pipeline control, program-memory and IF/ID signals.
//   slave  (fetch stage): takes stall/flush/redirect/target/instruction, drives pc_o and ifid_*/misaligned_o.
//   master (environment): the mirror image.
interface instruction_fetch_stage_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  stall_i;
    logic                  flush_i;
    logic                  redirect_i;
    logic [DATA_WIDTH-1:0] redirect_target_i;
    logic [DATA_WIDTH-1:0] instruction_i;
    logic [DATA_WIDTH-1:0] pc_o;
    logic [DATA_WIDTH-1:0] ifid_instruction_o;
    logic [DATA_WIDTH-1:0] ifid_pc_o;
    logic [DATA_WIDTH-1:0] ifid_pc_plus4_o;
    logic                  ifid_valid_o;
    logic                  misaligned_o;
    modport master (
        output stall_i, flush_i, redirect_i, redirect_target_i, instruction_i,
        input  pc_o, ifid_instruction_o, ifid_pc_o, ifid_pc_plus4_o, ifid_valid_o, misaligned_o
    );
    modport slave (
        input  stall_i, flush_i, redirect_i, redirect_target_i, instruction_i,
        output pc_o, ifid_instruction_o, ifid_pc_o, ifid_pc_plus4_o, ifid_valid_o, misaligned_o
    );
endinterface

// File: rtl/instruction_fetch_stage.sv
// instruction_fetch_stage: PC register plus IF/ID pipeline register with stall, flush and redirect.
//   clk, reset (sync, active-high); bus: slave side of instruction_fetch_stage_if.
module instruction_fetch_stage #(
    parameter int                  DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC  = 32'h0040_0000,
    parameter logic [DATA_WIDTH-1:0] NOP_INSTR = 32'h0000_0013
) (
    input logic                      clk,
    input logic                      reset,
    instruction_fetch_stage_if.slave bus
);
    logic [DATA_WIDTH-1:0] pc_q, pc_d, pc_plus4;
    logic [DATA_WIDTH-1:0] instr_q, instr_d, ipc_q, ipc_d, ipc4_q, ipc4_d;
    logic                  valid_q, valid_d, mis_q, mis_d, bubble, load;
    always_comb begin
        pc_plus4 = pc_q + DATA_WIDTH'(4);
        bubble   = bus.redirect_i | bus.flush_i;
        // a bubble still records this cycle's PC, so it captures like a load
        load     = bubble | ~bus.stall_i;
        pc_d     = bus.redirect_i ? {bus.redirect_target_i[DATA_WIDTH-1:2], 2'b00} :
                   bus.stall_i    ? pc_q : pc_plus4;
        instr_d  = bubble ? NOP_INSTR : bus.stall_i ? instr_q : bus.instruction_i;
        valid_d  = bubble ? 1'b0 : bus.stall_i ? valid_q : 1'b1;
        ipc_d    = load ? pc_q : ipc_q;
        ipc4_d   = load ? pc_plus4 : ipc4_q;
        mis_d    = mis_q | (bus.redirect_i & |bus.redirect_target_i[1:0]);
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q    <= RESET_PC;
            instr_q <= NOP_INSTR;
            ipc_q   <= '0;
            ipc4_q  <= '0;
            valid_q <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            ipc_q   <= ipc_d;
            ipc4_q  <= ipc4_d;
            valid_q <= valid_d;
            mis_q   <= mis_d;
        end
    end
    assign bus.pc_o               = pc_q;
    assign bus.ifid_instruction_o = instr_q;
    assign bus.ifid_pc_o          = ipc_q;
    assign bus.ifid_pc_plus4_o    = ipc4_q;
    assign bus.ifid_valid_o       = valid_q;
    assign bus.misaligned_o       = mis_q;
endmodule
